seq_matcher_multi: RTL and testbench

//  Parametrised successor to the single-pattern sequence analyzer.

---
 rtl/seq_matcher_multi.sv | 111 +++++++++++
 tb/tb_seq_matcher_multi.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seq_matcher_multi.sv
// Multi-pattern symbol sequence matcher: shifts CE-strobed symbols into a history,
// compares against runtime-programmable patterns and keeps saturating hit counts.
module seq_matcher_multi #(
  parameter int DW     = 4,
  parameter int DEPTH  = 4,
  parameter int N_PAT  = 2,
  parameter int PSEL_W = 1,
  parameter int CNT_W  = 8,
  parameter logic [N_PAT*DEPTH*DW-1:0] PAT_INIT = {16'h5A5A, 16'h1234}
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_ce,
  input  logic [DW-1:0]            i_dat,
  input  logic                     i_mode_ovl,
  input  logic                     i_clr,
  input  logic                     i_pat_we,
  input  logic [PSEL_W-1:0]        i_pat_sel,
  input  logic [DEPTH*DW-1:0]      i_pat_dat,
  output logic [DEPTH*DW-1:0]      o_hist,
  output logic [DEPTH-1:0]         o_valid_mask,
  output logic [N_PAT-1:0]         o_hit,
  output logic                     o_any_hit,
  output logic [N_PAT*CNT_W-1:0]   o_hit_cnt
);

  localparam int HW     = DEPTH * DW;
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [HW-1:0]     r_hist;
  logic [FILL_W-1:0] r_fill;
  logic [HW-1:0]     r_pat [N_PAT];
  logic [N_PAT-1:0]  r_hit;
  logic              r_any_hit;
  logic [CNT_W-1:0]  r_cnt [N_PAT];

  logic [HW-1:0]     w_hist_nxt;
  logic [FILL_W-1:0] w_fill_inc;
  logic [N_PAT-1:0]  w_match;
  logic              w_pat_sel_ok;

  // Matching looks at the history as it will be after this CE, against the
  // pattern registers as they stand before any same-cycle pattern write.
  always_comb begin
    w_hist_nxt = {r_hist[HW-DW-1:0], i_dat};
    w_fill_inc = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + FILL_W'(1);
    w_match    = '0;
    for (int p = 0; p < N_PAT; p++) begin
      w_match[p] = i_ce && (w_fill_inc == FILL_FULL) && (w_hist_nxt == r_pat[p]);
    end
    w_pat_sel_ok = (32'(i_pat_sel) < 32'(N_PAT));
  end

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // blocking assignments would let later statements see half-updated state.
  // NOTE: the pattern store is reset too: it is only N_PAT registers and must
  // come up holding PAT_INIT, so it is not treated as an unreset RAM.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_hit     <= '0;
      r_any_hit <= 1'b0;
      for (int p = 0; p < N_PAT; p++) begin
        r_cnt[p] <= '0;
        r_pat[p] <= PAT_INIT[p*HW +: HW];
      end
    end else begin
      r_hit     <= '0;
      r_any_hit <= 1'b0;
      if (i_clr) begin
        r_hist <= '0;
        r_fill <= '0;
        for (int p = 0; p < N_PAT; p++) begin
          r_cnt[p] <= '0;
        end
      end else if (i_ce) begin
        r_hist    <= w_hist_nxt;
        r_hit     <= w_match;
        r_any_hit <= |w_match;
        // Non-overlap mode invalidates the whole history after any hit.
        r_fill    <= (!i_mode_ovl && (|w_match)) ? '0 : w_fill_inc;
        for (int p = 0; p < N_PAT; p++) begin
          if (w_match[p] && (r_cnt[p] != CNT_MAX)) begin
            r_cnt[p] <= r_cnt[p] + CNT_W'(1);
          end
        end
      end
      if (i_pat_we && w_pat_sel_ok) begin
        r_pat[i_pat_sel] <= i_pat_dat;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_mask
      assign o_valid_mask[gi] = (r_fill > FILL_W'(gi));
    end
    for (gi = 0; gi < N_PAT; gi++) begin : g_cnt
      assign o_hit_cnt[gi*CNT_W +: CNT_W] = r_cnt[gi];
    end
  endgenerate

  assign o_hist    = r_hist;
  assign o_hit     = r_hit;
  assign o_any_hit = r_any_hit;

endmodule

// File: tb/tb_seq_matcher_multi.sv
// Directed bench for seq_matcher_multi: a reference model pushes expected outputs
// per cycle into a scoreboard; a second instance with 2-bit counters covers saturation.
module tb_seq_matcher_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ce, ovl, clr, we, sel;
  logic [3:0]  dat;
  logic [15:0] pdat;

  logic [15:0] o_hist,  o_hist2;
  logic [3:0]  o_mask,  o_mask2;
  logic [1:0]  o_hit,   o_hit2;
  logic        o_any,   o_any2;
  logic [15:0] o_cnt;
  logic [3:0]  o_cnt2;

  seq_matcher_multi u_dut (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_dat(dat), .i_mode_ovl(ovl), .i_clr(clr),
    .i_pat_we(we), .i_pat_sel(sel), .i_pat_dat(pdat),
    .o_hist(o_hist), .o_valid_mask(o_mask), .o_hit(o_hit), .o_any_hit(o_any), .o_hit_cnt(o_cnt)
  );

  seq_matcher_multi #(.CNT_W(2)) u_dut_c2 (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_dat(dat), .i_mode_ovl(ovl), .i_clr(clr),
    .i_pat_we(we), .i_pat_sel(sel), .i_pat_dat(pdat),
    .o_hist(o_hist2), .o_valid_mask(o_mask2), .o_hit(o_hit2), .o_any_hit(o_any2), .o_hit_cnt(o_cnt2)
  );

  typedef struct packed {
    logic [15:0] hist;
    logic [3:0]  mask;
    logic [1:0]  hit;
    logic        any;
    logic [15:0] cnt;
    logic [3:0]  cnt2;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [15:0] m_hist;
  int          m_fill;
  logic [15:0] m_pat [2];
  int          m_c8  [2];
  int          m_c2  [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input logic a_rst, input logic a_clr, input logic a_ce, input logic [3:0] a_dat,
                     input logic a_we = 1'b0, input logic a_sel = 1'b0, input logic [15:0] a_pdat = 16'h0);
    exp_t        e;
    exp_t        got;
    logic [1:0]  h;
    logic [15:0] nh;
    int          nf;
    @(negedge clk);
    rst = a_rst; clr = a_clr; ce = a_ce; dat = a_dat; we = a_we; sel = a_sel; pdat = a_pdat;
    h = 2'b00;
    if (a_rst) begin
      m_hist = 16'h0; m_fill = 0;
      m_c8[0] = 0; m_c8[1] = 0; m_c2[0] = 0; m_c2[1] = 0;
      m_pat[0] = 16'h1234; m_pat[1] = 16'h5A5A;
    end else begin
      if (a_clr) begin
        m_hist = 16'h0; m_fill = 0;
        m_c8[0] = 0; m_c8[1] = 0; m_c2[0] = 0; m_c2[1] = 0;
      end else if (a_ce) begin
        nh = {m_hist[11:0], a_dat};
        nf = (m_fill < 4) ? m_fill + 1 : 4;
        for (int p = 0; p < 2; p++) begin
          if (nf == 4 && nh == m_pat[p]) begin
            h[p] = 1'b1;
            if (m_c8[p] < 255) m_c8[p]++;
            if (m_c2[p] < 3)   m_c2[p]++;
          end
        end
        m_hist = nh;
        m_fill = (!ovl && h != 2'b00) ? 0 : nf;
      end
      if (a_we) m_pat[a_sel] = a_pdat;
    end
    e.hist = m_hist;
    for (int i = 0; i < 4; i++) e.mask[i] = (m_fill > i);
    e.hit  = h;
    e.any  = |h;
    e.cnt  = {m_c8[1][7:0], m_c8[0][7:0]};
    e.cnt2 = {m_c2[1][1:0], m_c2[0][1:0]};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check("hist",       32'(o_hist), 32'(got.hist));
    check("valid_mask", 32'(o_mask), 32'(got.mask));
    check("hit",        32'(o_hit),  32'(got.hit));
    check("any_hit",    32'(o_any),  32'(got.any));
    check("hit_cnt",    32'(o_cnt),  32'(got.cnt));
    check("hit_cnt_c2", 32'(o_cnt2), 32'(got.cnt2));
  endtask

  task automatic sym(input logic [3:0] d);
    cyc(1'b0, 1'b0, 1'b1, d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; clr = 1'b0; ce = 1'b0; we = 1'b0; sel = 1'b0; dat = 4'h0; pdat = 16'h0;
    ovl = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 1'b0, 4'h0);
    check("reset_hit_cnt", 32'(o_cnt), 32'h0);

    // 1,2,3,4 matches default pattern 0
    sym(4'h1); sym(4'h2); sym(4'h3); sym(4'h4);
    check("first_hit", 32'(o_hit), 32'h1);
    check("first_cnt0", 32'(o_cnt[7:0]), 32'h1);
    check("first_mask", 32'(o_mask), 32'hF);
    cyc(1'b0, 1'b0, 1'b0, 4'h0);
    check("hit_pulse_drop", 32'(o_hit), 32'h0);

    // overlapping 5,A,5,A,5,A
    sym(4'h5); sym(4'hA); sym(4'h5); sym(4'hA);
    check("ovl_hit4", 32'(o_hit), 32'h2);
    sym(4'h5); sym(4'hA);
    check("ovl_hit6", 32'(o_hit), 32'h2);
    check("ovl_cnt1", 32'(o_cnt[15:8]), 32'h2);

    // non-overlapping after a clear
    ovl = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, 4'h0);
    sym(4'h5); sym(4'hA); sym(4'h5); sym(4'hA);
    check("novl_hit4", 32'(o_hit), 32'h2);
    check("novl_mask_zero", 32'(o_mask), 32'h0);
    sym(4'h5); sym(4'hA);
    check("novl_no_hit6", 32'(o_hit), 32'h0);
    check("novl_mask_two", 32'(o_mask), 32'h3);
    check("novl_cnt1", 32'(o_cnt[15:8]), 32'h1);

    // reprogram pattern 1 to equal pattern 0 -> simultaneous hits
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 16'h1234);
    sym(4'h1); sym(4'h2); sym(4'h3); sym(4'h4);
    check("dual_hit", 32'(o_hit), 32'h3);

    // pattern write coinciding with the matching CE uses the old pattern
    ovl = 1'b1;
    sym(4'h1); sym(4'h2); sym(4'h3);
    cyc(1'b0, 1'b0, 1'b1, 4'h4, 1'b1, 1'b0, 16'hFFFF);
    check("old_pat_hit", 32'(o_hit), 32'h3);
    sym(4'hF); sym(4'hF); sym(4'hF); sym(4'hF);
    check("new_pat_hit", 32'(o_hit), 32'h1);
    sym(4'hF); sym(4'hF);
    check("cnt0_five", 32'(o_cnt[7:0]), 32'h5);
    check("cnt0_saturated_c2", 32'(o_cnt2[1:0]), 32'h3);

    // CLR together with the 3rd CE discards it
    sym(4'h1); sym(4'h2);
    cyc(1'b0, 1'b1, 1'b1, 4'h3);
    check("clr_mask", 32'(o_mask), 32'h0);
    sym(4'h4);
    check("clr_no_hit", 32'(o_hit), 32'h0);
    check("clr_mask_one", 32'(o_mask), 32'h1);
    check("clr_cnt", 32'(o_cnt), 32'h0);

    // reset mid-sequence restores patterns and clears everything
    sym(4'h1); sym(4'h2);
    cyc(1'b1, 1'b0, 1'b0, 4'h0);
    check("rst_hist", 32'(o_hist), 32'h0);
    check("rst_mask", 32'(o_mask), 32'h0);
    sym(4'h3); sym(4'h4);
    check("rst_no_hit", 32'(o_hit), 32'h0);
    sym(4'h5); sym(4'hA); sym(4'h5); sym(4'hA);
    check("rst_pat_restored", 32'(o_hit), 32'h2);
    cyc(1'b0, 1'b0, 1'b0, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
